// File: rtl/count_capture_fifo_if.sv
// count_capture_fifo_if: capture-side inputs and show-ahead read port of count_capture_fifo.
interface count_capture_fifo_if #(
    parameter int N          = 4,
    parameter int DEPTH_LOG2 = 2
);
    logic [N-1:0]        count_in;
    logic                capture;
    logic                clr_overflow;
    logic                rd_ready;
    logic                rd_valid;
    logic [N:0]          rd_data;
    logic [DEPTH_LOG2:0] fill_level;
    logic                full;
    logic                empty;
    logic                overflow;
    modport master (
        output count_in, capture, clr_overflow, rd_ready,
        input  rd_valid, rd_data, fill_level, full, empty, overflow
    );
    modport slave (
        input  count_in, capture, clr_overflow, rd_ready,
        output rd_valid, rd_data, fill_level, full, empty, overflow
    );
endinterface

// File: rtl/count_capture_fifo.sv
// count_capture_fifo: snapshots a free-running counter into a FIFO, tagging each entry with a wrap flag.
// Define CAPTURE_EDGE_EN to store only on the rising edge of capture instead of every high cycle.
module count_capture_fifo #(
    parameter int N          = 4,
    parameter int DEPTH_LOG2 = 2
) (
    input logic                 clk,
    input logic                 reset,
    count_capture_fifo_if.slave bus
);
    localparam int FW = DEPTH_LOG2 + 1;
    localparam int DEPTH = 2 ** DEPTH_LOG2;
    logic [DEPTH_LOG2-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [FW-1:0]         fill_q, fill_d;
    logic                  overflow_q, overflow_d;
    logic                  wrap_pending_q, wrap_pending_d;
    logic [N-1:0]          prev_count_q, prev_count_d;
    logic [N:0]            mem_q [DEPTH];
    logic [N:0]            mem_d [DEPTH];
    logic                  cap, wrap_now, pop, push, is_full, is_valid;
`ifdef CAPTURE_EDGE_EN
    logic capture_prev_q;
    always_ff @(posedge clk) begin
        if (reset) capture_prev_q <= 1'b0;
        else       capture_prev_q <= bus.capture;
    end
    assign cap = bus.capture && !capture_prev_q;
`else
    assign cap = bus.capture;
`endif
    always_comb begin
        is_full        = fill_q == FW'(DEPTH);
        is_valid       = fill_q != '0;
        wrap_now       = (prev_count_q == '1) && (bus.count_in == '0);
        pop            = is_valid && bus.rd_ready;
        push           = cap && (!is_full || pop);
        mem_d          = mem_q;
        if (push) mem_d[wr_ptr_q] = {wrap_pending_q || wrap_now, bus.count_in};
        wr_ptr_d       = wr_ptr_q + DEPTH_LOG2'(push);
        rd_ptr_d       = rd_ptr_q + DEPTH_LOG2'(pop);
        fill_d         = fill_q + FW'(push) - FW'(pop);
        // a dropped capture keeps the wrap so the next stored entry still reports it
        wrap_pending_d = !push && (wrap_pending_q || wrap_now);
        overflow_d     = (cap && !push) || (overflow_q && !bus.clr_overflow);
        prev_count_d   = bus.count_in;
    end
    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr_q       <= '0;
            rd_ptr_q       <= '0;
            fill_q         <= '0;
            overflow_q     <= 1'b0;
            wrap_pending_q <= 1'b0;
            prev_count_q   <= '0;
        end else begin
            wr_ptr_q       <= wr_ptr_d;
            rd_ptr_q       <= rd_ptr_d;
            fill_q         <= fill_d;
            overflow_q     <= overflow_d;
            wrap_pending_q <= wrap_pending_d;
            prev_count_q   <= prev_count_d;
        end
    end
    always_ff @(posedge clk) mem_q <= mem_d;
    assign bus.rd_valid   = is_valid;
    assign bus.rd_data    = is_valid ? mem_q[rd_ptr_q] : '0;
    assign bus.fill_level = fill_q;
    assign bus.full       = is_full;
    assign bus.empty      = !is_valid;
    assign bus.overflow   = overflow_q;
endmodule

// File: tb/tb_count_capture_fifo.sv
// tb_count_capture_fifo: directed vector table, hand sequences and a queue-based random reference check.
module tb_count_capture_fifo;
    localparam int N = 4;
    localparam int DL = 2;
    localparam int DEPTH = 4;
    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;
    count_capture_fifo_if #(.N(N), .DEPTH_LOG2(DL)) bus ();
    count_capture_fifo #(.N(N), .DEPTH_LOG2(DL)) dut (.clk(clk), .reset(reset), .bus(bus));
    int n_cmp = 0;
    int n_bad = 0;
    logic [N:0]   mq[$];
    bit           m_ovf, m_wp, m_cp;
    logic [N-1:0] m_prev;
    typedef struct {
        bit r; int c; bit cap; bit clr; bit rdy;
        bit v; int d; int f; bit fl; bit ov;
    } vec_t;
    vec_t tbl[$];
    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask
    task automatic cycle(input bit r, input int c, input bit cap, input bit clr, input bit rdy);
        reset = r;
        bus.count_in = c[N-1:0];
        bus.capture = cap;
        bus.clr_overflow = clr;
        bus.rd_ready = rdy;
        if (r) begin
            mq.delete();
            m_ovf = 0; m_wp = 0; m_prev = '0; m_cp = 0;
        end else begin
            bit capq, wrap, pop, push;
            int sz;
            sz = mq.size();
`ifdef CAPTURE_EDGE_EN
            capq = cap && !m_cp;
`else
            capq = cap;
`endif
            wrap = (m_prev == {N{1'b1}}) && (c[N-1:0] == 0);
            pop = sz > 0 && rdy;
            push = capq && (sz < DEPTH || pop);
            if (pop) void'(mq.pop_front());
            if (push) begin
                mq.push_back({m_wp | wrap, c[N-1:0]});
                m_wp = 0;
            end else m_wp = m_wp | wrap;
            if (capq && !push) m_ovf = 1;
            else if (clr) m_ovf = 0;
            m_prev = c[N-1:0];
            m_cp = cap;
        end
        @(posedge clk);
        #1;
    endtask
    task automatic check_model(input string tag);
        logic [N:0] head;
        head = mq.size() > 0 ? mq[0] : '0;
        check({tag, " valid"}, 32'(bus.rd_valid), 32'(mq.size() > 0));
        check({tag, " data"}, 32'(bus.rd_data), 32'(head));
        check({tag, " fill"}, 32'(bus.fill_level), 32'(mq.size()));
        check({tag, " full"}, 32'(bus.full), 32'(mq.size() == DEPTH));
        check({tag, " empty"}, 32'(bus.empty), 32'(mq.size() == 0));
        check({tag, " overflow"}, 32'(bus.overflow), 32'(m_ovf));
    endtask
    initial begin
        int cnt;
        // r c cap clr rdy | valid data fill full ovf
        tbl.push_back('{1, 7, 1, 0, 0, 0, 0, 0, 0, 0});
        tbl.push_back('{1, 7, 1, 0, 0, 0, 0, 0, 0, 0});
        tbl.push_back('{0, 5, 1, 0, 0, 1, 5, 1, 0, 0});
        tbl.push_back('{0, 5, 0, 0, 1, 0, 0, 0, 0, 0});
        tbl.push_back('{0, 14, 0, 0, 0, 0, 0, 0, 0, 0});
        tbl.push_back('{0, 15, 0, 0, 0, 0, 0, 0, 0, 0});
        tbl.push_back('{0, 0, 0, 0, 0, 0, 0, 0, 0, 0});
        tbl.push_back('{0, 1, 0, 0, 0, 0, 0, 0, 0, 0});
        tbl.push_back('{0, 2, 0, 0, 0, 0, 0, 0, 0, 0});
        tbl.push_back('{0, 3, 1, 0, 0, 1, 19, 1, 0, 0});
        tbl.push_back('{0, 4, 0, 0, 0, 1, 19, 1, 0, 0});
        tbl.push_back('{0, 5, 1, 0, 0, 1, 19, 2, 0, 0});
        tbl.push_back('{0, 5, 0, 0, 1, 1, 5, 1, 0, 0});
        tbl.push_back('{0, 5, 0, 0, 1, 0, 0, 0, 0, 0});
        for (int k = 1; k <= 4; k++) begin
            tbl.push_back('{0, k, 1, 0, 0, 1, 1, k, k == 4, 0});
            tbl.push_back('{0, k, 0, 0, 0, 1, 1, k, k == 4, 0});
        end
        tbl.push_back('{0, 5, 1, 1, 0, 1, 1, 4, 1, 1});
        tbl.push_back('{0, 5, 0, 0, 1, 1, 2, 3, 0, 1});
        tbl.push_back('{0, 5, 0, 0, 1, 1, 3, 2, 0, 1});
        tbl.push_back('{0, 5, 0, 0, 1, 1, 4, 1, 0, 1});
        tbl.push_back('{0, 5, 0, 0, 1, 0, 0, 0, 0, 1});
        tbl.push_back('{0, 5, 0, 1, 0, 0, 0, 0, 0, 0});
        for (int k = 1; k <= 4; k++) begin
            tbl.push_back('{0, k, 1, 0, 0, 1, 1, k, k == 4, 0});
            tbl.push_back('{0, k, 0, 0, 0, 1, 1, k, k == 4, 0});
        end
        tbl.push_back('{0, 9, 1, 0, 1, 1, 2, 4, 1, 0});
        tbl.push_back('{0, 9, 0, 0, 1, 1, 3, 3, 0, 0});
        tbl.push_back('{0, 9, 0, 0, 1, 1, 4, 2, 0, 0});
        tbl.push_back('{0, 9, 0, 0, 1, 1, 9, 1, 0, 0});
        tbl.push_back('{0, 9, 0, 0, 1, 0, 0, 0, 0, 0});
        foreach (tbl[i]) begin
            cycle(tbl[i].r, tbl[i].c, tbl[i].cap, tbl[i].clr, tbl[i].rdy);
            check($sformatf("row%0d valid", i), 32'(bus.rd_valid), 32'(tbl[i].v));
            check($sformatf("row%0d data", i), 32'(bus.rd_data), tbl[i].d);
            check($sformatf("row%0d fill", i), 32'(bus.fill_level), tbl[i].f);
            check($sformatf("row%0d full", i), 32'(bus.full), 32'(tbl[i].fl));
            check($sformatf("row%0d empty", i), 32'(bus.empty), 32'(tbl[i].f == 0));
            check($sformatf("row%0d overflow", i), 32'(bus.overflow), 32'(tbl[i].ov));
        end
        // capture held high through reset release and for six cycles
        cycle(1, 6, 1, 0, 0);
        for (int k = 0; k < 6; k++) cycle(0, 6, 1, 0, 0);
`ifdef CAPTURE_EDGE_EN
        check("held fill", 32'(bus.fill_level), 1);
        check("held overflow", 32'(bus.overflow), 0);
`else
        check("held fill", 32'(bus.fill_level), 4);
        check("held overflow", 32'(bus.overflow), 1);
`endif
        check("held data", 32'(bus.rd_data), 6);
        cycle(0, 6, 0, 0, 1);
`ifdef CAPTURE_EDGE_EN
        check("held pop fill", 32'(bus.fill_level), 0);
`else
        check("held pop fill", 32'(bus.fill_level), 3);
`endif
        cycle(1, 6, 0, 0, 0);
        check("midreset valid", 32'(bus.rd_valid), 0);
        check("midreset data", 32'(bus.rd_data), 0);
        check("midreset fill", 32'(bus.fill_level), 0);
        check("midreset full", 32'(bus.full), 0);
        check("midreset empty", 32'(bus.empty), 1);
        check("midreset overflow", 32'(bus.overflow), 0);
        cnt = 0;
        cycle(1, 0, 0, 0, 0);
        for (int i = 0; i < 3000; i++) begin
            cnt = ($urandom_range(0, 15) == 0) ? int'($urandom_range(0, 15)) : (cnt + 1) % 16;
            cycle($urandom_range(0, 199) == 0, cnt, $urandom_range(0, 1) == 1,
                  $urandom_range(0, 19) == 0, $urandom_range(0, 9) < 4);
            check_model($sformatf("rand%0d", i));
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
